bcd_countdown_timer: RTL
========================

# bcd_countdown_timer

Three-digit BCD countdown timer (seconds, tenths, hundredths), the decrementing counterpart to the team's stopwatch up-counter. It loads a preset time, counts down to 0.00 at a programmable tick rate, and flags expiry. It sits beside the stopwatch in the timing subsystem and drives the same three-digit BCD display path.

## Interface

Parameters:
- TICK_DIV, default 4: clk cycles per hundredth-of-a-second decrement; legal range is 1 to 65535.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high.
- clear  in  1  synchronous abort: zeroes the digits and returns to IDLE.
- load  in  1  latch the preset digits.
- load_sec  in  4  preset seconds digit.
- load_tenth  in  4  preset tenths digit.
- load_hundredth  in  4  preset hundredths digit.
- start  in  1  begin or resume the countdown.
- pause  in  1  freeze the countdown.
- sec  out  4  current seconds digit, BCD.
- tenth  out  4  current tenths digit, BCD.
- hundredth  out  4  current hundredths digit, BCD.
- running  out  1  high while in RUN.
- expired  out  1  level, high while in DONE.
- done  out  1  single-cycle pulse when the count reaches 0.00.

## Operation

- States: IDLE, RUN, PAUSE, DONE. Encoding is free.
- Control priority within a cycle: clear > load > start > pause.
- Load rules:
  - Each preset digit above 9 is clamped to 9. Example: load_sec=4'hC latches 9.
  - Load is honoured in IDLE, PAUSE and DONE. It is ignored in RUN.
- IDLE:
  - load latches the digits and the block stays in IDLE.
  - start with digits non-zero moves to RUN and zeroes the prescaler.
  - start with digits 0.00 is ignored: the block stays in IDLE and done stays low.
- RUN:
  - The prescaler counts 0 to TICK_DIV-1. At TICK_DIV-1 it wraps to 0 and one BCD decrement occurs.
  - BCD decrement with borrow:
    - hundredth 0 becomes 9 and borrows from tenth.
    - tenth 0 becomes 9 and borrows from sec.
  - If the pre-decrement value is 0.01, the digits become 0.00, the state becomes DONE and done pulses, all on the same edge.
  - pause moves to PAUSE with the prescaler value held. If pause and the tick occur in the same cycle, pause wins and there is no decrement.
  - start has no effect.
- PAUSE:
  - Digits and prescaler are frozen.
  - start returns to RUN, and the prescaler resumes from its held value.
  - load latches the digits and the block stays in PAUSE.
  - If the loaded value is 0.00, a later start is ignored and the block stays in PAUSE.
- DONE:
  - Digits hold 0.00 and expired=1.
  - load latches the digits and moves to IDLE.
  - start and pause are ignored.
- clear in any state: digits become 0.00, prescaler becomes 0, state becomes IDLE, done=0.
- Digits never leave the range 0 to 9 and the count never wraps below 0.00.

## Timing

- All outputs are registered.
- Reset values: sec=0, tenth=0, hundredth=0, running=0, expired=0, done=0, prescaler=0, state IDLE.
- Reset asserted mid-count returns everything to the reset values immediately, with no done pulse.
- Load latency: digits show the preset value on the edge that samples load.
- Start latency:
  - running goes high on the edge that samples start.
  - The first decrement lands TICK_DIV edges later.
  - Each further decrement follows every TICK_DIV edges.
- Total run time from a preset of N hundredths is N×TICK_DIV cycles, provided there is no pause.
- done is high for exactly one cycle, on the same edge where the digits reach 0.00. expired and running change on that same edge.
- TICK_DIV=1 gives one decrement per edge in RUN.

## Test plan

- TICK_DIV=4: load 0.03, start, run uninterrupted.
  - Decrements to 0.02, 0.01, 0.00 occur 4, 8 and 12 edges after start.
  - done is high for one cycle together with 0.00.
  - expired=1 and running=0 from that edge on.
- Borrow chain: load 1.00, start.
  - After 4 edges the digits read 0.99.
  - From preset 1.00, done occurs 400 edges after start.
- Pause/resume: load 0.05, start.
  - Assert pause at start+6: the digits freeze at 0.04 and hold for 20 cycles.
  - After start again, the next decrement lands 2 edges later, because the prescaler was held at 2.
- Edge cases:
  - Load with digits 12/10/15: latches 9.99.
  - start with digits 0.00 in IDLE: the block stays in IDLE and done never pulses.
  - load asserted during RUN: ignored, and the count continues.
- Collisions:
  - clear together with load and start in RUN: digits 0.00, state IDLE, running=0.
  - pause on the tick edge: no decrement.
- Async reset asserted mid-RUN at 0.50: all outputs 0 immediately and no done pulse. After reset releases, the block stays in IDLE.

Source files
------------

// File: rtl/bcd_countdown_timer_if.sv
// Control and display bundle for the three-digit BCD countdown timer.
// Latency: none; pure signal grouping.
// Backpressure: none; the timer samples controls every cycle.
interface bcd_countdown_timer_if;
  logic       clear;
  logic       load;
  logic [3:0] load_sec;
  logic [3:0] load_tenth;
  logic [3:0] load_hundredth;
  logic       start;
  logic       pause;
  logic [3:0] sec;
  logic [3:0] tenth;
  logic [3:0] hundredth;
  logic       running;
  logic       expired;
  logic       done;

  // Controller side: drives controls, watches the display and status.
  modport master (
    output clear, load, load_sec, load_tenth, load_hundredth, start, pause,
    input  sec, tenth, hundredth, running, expired, done
  );

  // Timer side.
  modport slave (
    input  clear, load, load_sec, load_tenth, load_hundredth, start, pause,
    output sec, tenth, hundredth, running, expired, done
  );
endinterface

// File: rtl/bcd_countdown_timer.sv
// BCD countdown timer (s.t h digits) with preset load, pause/resume and expiry flag.
// Latency: load/start visible on the sampling edge; first decrement TICK_DIV edges after start.
// Backpressure: none; controls are sampled every cycle with priority clear > load > start > pause.
module bcd_countdown_timer #(
  parameter int TICK_DIV = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  bcd_countdown_timer_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_sec, r_tenth, r_hund;
  logic [3:0]  w_sec_nxt, w_tenth_nxt, w_hund_nxt;
  logic [15:0] r_presc;
  logic [15:0] w_presc_nxt;
  logic        r_running, r_expired, r_done;
  logic        w_done_nxt;

  logic        w_nonzero;
  logic        w_is_last;
  logic [3:0]  w_dec_sec, w_dec_tenth, w_dec_hund;
  logic [3:0]  w_ld_sec, w_ld_tenth, w_ld_hund;

  assign w_nonzero = (r_sec != 4'd0) || (r_tenth != 4'd0) || (r_hund != 4'd0);
  assign w_is_last = (r_sec == 4'd0) && (r_tenth == 4'd0) && (r_hund == 4'd1);

  // Preset digits above 9 are clamped so the display never shows a non-BCD code.
  assign w_ld_sec   = (bus.load_sec       > 4'd9) ? 4'd9 : bus.load_sec;
  assign w_ld_tenth = (bus.load_tenth     > 4'd9) ? 4'd9 : bus.load_tenth;
  assign w_ld_hund  = (bus.load_hundredth > 4'd9) ? 4'd9 : bus.load_hundredth;

  // One-hundredth decrement with borrow through tenths into seconds.
  always_comb begin
    w_dec_sec   = r_sec;
    w_dec_tenth = r_tenth;
    w_dec_hund  = r_hund;
    if (r_hund != 4'd0) begin
      w_dec_hund = r_hund - 4'd1;
    end else begin
      w_dec_hund = 4'd9;
      if (r_tenth != 4'd0) begin
        w_dec_tenth = r_tenth - 4'd1;
      end else begin
        w_dec_tenth = 4'd9;
        w_dec_sec   = r_sec - 4'd1;
      end
    end
  end

  // Next-state, digit and prescaler logic for the IDLE/RUN/PAUSE/DONE controller.
  always_comb begin
    w_state_nxt = r_state;
    w_sec_nxt   = r_sec;
    w_tenth_nxt = r_tenth;
    w_hund_nxt  = r_hund;
    w_presc_nxt = r_presc;
    w_done_nxt  = 1'b0;

    if (bus.clear) begin
      w_state_nxt = S_IDLE;
      w_sec_nxt   = 4'd0;
      w_tenth_nxt = 4'd0;
      w_hund_nxt  = 4'd0;
      w_presc_nxt = 16'd0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.load) begin
            w_sec_nxt   = w_ld_sec;
            w_tenth_nxt = w_ld_tenth;
            w_hund_nxt  = w_ld_hund;
          end else if (bus.start && w_nonzero) begin
            w_state_nxt = S_RUN;
            w_presc_nxt = 16'd0;
          end
        end
        S_RUN: begin
          // load and start are ignored while counting; pause beats a same-cycle tick.
          if (bus.pause) begin
            w_state_nxt = S_PAUSE;
          end else if (r_presc == TICK_LAST) begin
            w_presc_nxt = 16'd0;
            if (w_is_last) begin
              w_sec_nxt   = 4'd0;
              w_tenth_nxt = 4'd0;
              w_hund_nxt  = 4'd0;
              w_state_nxt = S_DONE;
              w_done_nxt  = 1'b1;
            end else if (w_nonzero) begin
              w_sec_nxt   = w_dec_sec;
              w_tenth_nxt = w_dec_tenth;
              w_hund_nxt  = w_dec_hund;
            end
          end else begin
            w_presc_nxt = r_presc + 16'd1;
          end
        end
        S_PAUSE: begin
          // Prescaler stays frozen so a resume finishes the interrupted tick period.
          if (bus.load) begin
            w_sec_nxt   = w_ld_sec;
            w_tenth_nxt = w_ld_tenth;
            w_hund_nxt  = w_ld_hund;
          end else if (bus.start && w_nonzero) begin
            w_state_nxt = S_RUN;
          end
        end
        S_DONE: begin
          if (bus.load) begin
            w_sec_nxt   = w_ld_sec;
            w_tenth_nxt = w_ld_tenth;
            w_hund_nxt  = w_ld_hund;
            w_state_nxt = S_IDLE;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // State, digits, prescaler and registered status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_sec     <= 4'd0;
      r_tenth   <= 4'd0;
      r_hund    <= 4'd0;
      r_presc   <= 16'd0;
      r_running <= 1'b0;
      r_expired <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_sec     <= w_sec_nxt;
      r_tenth   <= w_tenth_nxt;
      r_hund    <= w_hund_nxt;
      r_presc   <= w_presc_nxt;
      r_running <= (w_state_nxt == S_RUN);
      r_expired <= (w_state_nxt == S_DONE);
      r_done    <= w_done_nxt;
    end
  end

  assign bus.sec       = r_sec;
  assign bus.tenth     = r_tenth;
  assign bus.hundredth = r_hund;
  assign bus.running   = r_running;
  assign bus.expired   = r_expired;
  assign bus.done      = r_done;

endmodule
